// File: rtl/segre_dmem_ctrl_if.sv
// rtl/segre_dmem_ctrl_if.sv - data memory bus between segre_dmem_ctrl and the data memory
interface segre_dmem_ctrl_if #(
  parameter int WORD_SIZE = 32
);

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [WORD_SIZE-1:0] mem_addr_o;
  logic [3:0]           mem_be_o;
  logic [WORD_SIZE-1:0] mem_wdata_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [WORD_SIZE-1:0] mem_rdata_i;

  // Controller side: issues requests, receives grant and response
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  // Memory side: accepts requests, returns grant and response
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/segre_dmem_ctrl.sv
// rtl/segre_dmem_ctrl.sv - MEM-stage data memory access controller (req/gnt/rvalid)
module segre_dmem_ctrl #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [1:0]           memop_type_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 stall_o,
  output logic                 misaligned_o,
  segre_dmem_ctrl_if.master    bus
);

  // memop_data_type_e encoding; 3 is not a legal type and behaves as a word
  localparam logic [1:0] MEMOP_BYTE = 2'd0;
  localparam logic [1:0] MEMOP_HALF = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e               state;
  logic [1:0]           offset_q;
  logic [1:0]           type_q;
  logic                 op;
  logic [3:0]           be_in;
  logic [WORD_SIZE-1:0] wdata_in;
  logic [WORD_SIZE-1:0] rdata_shifted;
  logic [WORD_SIZE-1:0] load_data;

  assign op = memop_rd_i | memop_wr_i;

  // Alignment check on the incoming request; a misaligned op never reaches the bus
  always_comb begin
    misaligned_o = 1'b0;
    case (memop_type_i)
      MEMOP_BYTE: misaligned_o = 1'b0;
      MEMOP_HALF: misaligned_o = op & addr_i[0];
      default:    misaligned_o = op & (addr_i[1:0] != 2'b00);
    endcase
  end

  // Pipeline is held until the access reaches DONE, where the result is consumed
  assign stall_o = op & ~misaligned_o & (state != DONE);

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = data_i;
    case (memop_type_i)
      MEMOP_BYTE: begin
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{data_i[7:0]}};
      end
      MEMOP_HALF: begin
        be_in    = 4'b0011 << addr_i[1:0];
        wdata_in = {2{data_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = data_i;
      end
    endcase
  end

  // Right-align the addressed bytes of the response and clear the unused upper bits
  always_comb begin
    rdata_shifted = bus.mem_rdata_i >> {offset_q, 3'b000};
    load_data     = rdata_shifted;
    case (type_q)
      MEMOP_BYTE: load_data = {{(WORD_SIZE-8){1'b0}}, rdata_shifted[7:0]};
      MEMOP_HALF: load_data = {{(WORD_SIZE-16){1'b0}}, rdata_shifted[15:0]};
      default:    load_data = rdata_shifted;
    endcase
  end

  // Transaction FSM with registered bus outputs and load result
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state           <= IDLE;
      offset_q        <= 2'b00;
      type_q          <= 2'b00;
      data_o          <= '0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_be_o    <= 4'b0000;
      bus.mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op && !misaligned_o) begin
            offset_q        <= addr_i[1:0];
            type_q          <= memop_type_i;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= memop_wr_i;
            bus.mem_addr_o  <= {addr_i[WORD_SIZE-1:2], 2'b00};
            bus.mem_be_o    <= be_in;
            bus.mem_wdata_o <= wdata_in;
            state           <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            if (bus.mem_rvalid_i) begin
              if (!bus.mem_we_o) data_o <= load_data;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (!bus.mem_we_o) data_o <= load_data;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_dmem_ctrl.sv
// tb/tb_segre_dmem_ctrl.sv - self-checking bench for segre_dmem_ctrl
module tb_segre_dmem_ctrl;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        memop_rd_i;
  logic        memop_wr_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [1:0]  memop_type_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        misaligned_o;

  segre_dmem_ctrl_if #(.WORD_SIZE(32)) bus ();

  segre_dmem_ctrl #(.WORD_SIZE(32)) dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .memop_rd_i   (memop_rd_i),
    .memop_wr_i   (memop_wr_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .memop_type_i (memop_type_i),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .misaligned_o (misaligned_o),
    .bus          (bus.master)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [1:0]  typ;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } op_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] sb_q[$];
  op_t         tbl[9];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input op_t t, input string where);
    check_eq({t.name, " ", where, " req"},   {31'd0, bus.mem_req_o}, 32'd1);
    check_eq({t.name, " ", where, " we"},    {31'd0, bus.mem_we_o}, {31'd0, t.wr});
    check_eq({t.name, " ", where, " addr"},  bus.mem_addr_o, t.exp_maddr);
    check_eq({t.name, " ", where, " be"},    {28'd0, bus.mem_be_o}, {28'd0, t.exp_be});
    check_eq({t.name, " ", where, " wdata"}, bus.mem_wdata_o, t.exp_wdata);
    check_eq({t.name, " ", where, " stall"}, {31'd0, stall_o}, 32'd1);
  endtask

  // Drives one op starting just after a rising edge; bus responses are timed from the table
  task automatic run_op(input op_t t);
    logic [31:0] exp;
    memop_rd_i   = t.rd;
    memop_wr_i   = t.wr;
    addr_i       = t.addr;
    data_i       = t.wdata_in;
    memop_type_i = t.typ;
    sb_q.push_back(t.exp_data);
    @(negedge clk_i);
    check_eq({t.name, " c0 stall"}, {31'd0, stall_o}, 32'd1);
    check_eq({t.name, " c0 req"}, {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk_i); #1;
    for (int i = 0; i < t.gnt_dly; i++) begin
      @(negedge clk_i);
      check_bus(t, "nognt");
      @(posedge clk_i); #1;
    end
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = (t.rv_dly == 0);
    bus.mem_rdata_i  = t.rdata;
    @(negedge clk_i);
    check_bus(t, "gnt");
    @(posedge clk_i); #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h5555_AAAA;
    if (t.rv_dly > 0) begin
      for (int i = 1; i < t.rv_dly; i++) begin
        @(negedge clk_i);
        check_eq({t.name, " wait req"}, {31'd0, bus.mem_req_o}, 32'd0);
        check_eq({t.name, " wait stall"}, {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
      end
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = t.rdata;
      @(negedge clk_i);
      check_eq({t.name, " rv stall"}, {31'd0, stall_o}, 32'd1);
      @(posedge clk_i); #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h5555_AAAA;
    end
    @(negedge clk_i);
    check_eq({t.name, " done stall"}, {31'd0, stall_o}, 32'd0);
    check_eq({t.name, " sb nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check_eq({t.name, " data_o"}, data_o, exp);
    end
    @(posedge clk_i); #1;
    memop_rd_i = 1'b0;
    memop_wr_i = 1'b0;
    @(negedge clk_i);
    check_eq({t.name, " after stall"}, {31'd0, stall_o}, 32'd0);
    check_eq({t.name, " after req"}, {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    tbl[0] = '{"lw100", 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 0, 2, 32'hDEADBEEF, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{"lb103", 1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 0, 0, 32'h80112233, 4'b1000, 32'h100, 32'h0, 32'h00000080};
    tbl[2] = '{"sh202", 1'b0, 1'b1, 32'h202, 32'h0000ABCD, 2'd1, 0, 1, 32'hFFFFFFFF, 4'b1100, 32'h200, 32'hABCDABCD, 32'h00000080};
    tbl[3] = '{"lh102", 1'b1, 1'b0, 32'h102, 32'h0, 2'd1, 1, 0, 32'h12345678, 4'b1100, 32'h100, 32'h0, 32'h00001234};
    tbl[4] = '{"t3w104", 1'b1, 1'b0, 32'h104, 32'h0, 2'd3, 0, 1, 32'hCAFEF00D, 4'b1111, 32'h104, 32'h0, 32'hCAFEF00D};
    tbl[5] = '{"sb101g5", 1'b0, 1'b1, 32'h101, 32'h000000A5, 2'd0, 5, 1, 32'h0, 4'b0010, 32'h100, 32'hA5A5A5A5, 32'hCAFEF00D};
    tbl[6] = '{"rdwr108", 1'b1, 1'b1, 32'h108, 32'h5A5A1234, 2'd2, 0, 0, 32'hFFFFFFFF, 4'b1111, 32'h108, 32'h5A5A1234, 32'hCAFEF00D};
    tbl[7] = '{"lb102", 1'b1, 1'b0, 32'h102, 32'h0, 2'd0, 2, 2, 32'h00FF0000, 4'b0100, 32'h100, 32'h0, 32'h000000FF};
    tbl[8] = '{"lw_post", 1'b1, 1'b0, 32'h400, 32'h0, 2'd2, 0, 0, 32'h0BADF00D, 4'b1111, 32'h400, 32'h0, 32'h0BADF00D};

    rsn_i            = 1'b1;
    memop_rd_i       = 1'b0;
    memop_wr_i       = 1'b0;
    addr_i           = 32'h0;
    data_i           = 32'h0;
    memop_type_i     = 2'd0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    repeat (3) @(posedge clk_i);
    #1 rsn_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst req",   {31'd0, bus.mem_req_o}, 32'd0);
    check_eq("rst we",    {31'd0, bus.mem_we_o}, 32'd0);
    check_eq("rst addr",  bus.mem_addr_o, 32'd0);
    check_eq("rst be",    {28'd0, bus.mem_be_o}, 32'd0);
    check_eq("rst wdata", bus.mem_wdata_o, 32'd0);
    check_eq("rst data",  data_o, 32'd0);
    check_eq("rst stall", {31'd0, stall_o}, 32'd0);

    // Stray response while idle must not disturb data_o
    @(posedge clk_i); #1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h77777777;
    @(posedge clk_i); #1;
    bus.mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle rvalid data", data_o, 32'd0);
    @(posedge clk_i); #1;

    for (int k = 0; k < 8; k++) run_op(tbl[k]);

    // Misaligned word and half: no stall, no request
    memop_rd_i   = 1'b1;
    addr_i       = 32'h101;
    memop_type_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("lw101 misaligned", {31'd0, misaligned_o}, 32'd1);
      check_eq("lw101 stall", {31'd0, stall_o}, 32'd0);
      check_eq("lw101 req", {31'd0, bus.mem_req_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    memop_rd_i   = 1'b0;
    memop_wr_i   = 1'b1;
    addr_i       = 32'h203;
    memop_type_i = 2'd1;
    @(negedge clk_i);
    check_eq("sh203 misaligned", {31'd0, misaligned_o}, 32'd1);
    check_eq("sh203 stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("sh203 req", {31'd0, bus.mem_req_o}, 32'd0);
    memop_wr_i = 1'b0;
    @(negedge clk_i);
    check_eq("noop misaligned", {31'd0, misaligned_o}, 32'd0);
    @(posedge clk_i); #1;

    // Reset while waiting for the response; the late rvalid must be ignored
    memop_rd_i   = 1'b1;
    addr_i       = 32'h300;
    memop_type_i = 2'd2;
    @(posedge clk_i); #1;
    bus.mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_gnt_i = 1'b0;
    @(negedge clk_i);
    check_eq("rstw wait stall", {31'd0, stall_o}, 32'd1);
    check_eq("rstw wait req", {31'd0, bus.mem_req_o}, 32'd0);
    rsn_i      = 1'b1;
    memop_rd_i = 1'b0;
    @(posedge clk_i); #1;
    rsn_i = 1'b0;
    @(negedge clk_i);
    check_eq("rstw req", {31'd0, bus.mem_req_o}, 32'd0);
    check_eq("rstw data", data_o, 32'd0);
    check_eq("rstw stall", {31'd0, stall_o}, 32'd0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h11111111;
    @(posedge clk_i); #1;
    bus.mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_eq("late rv data", data_o, 32'd0);
    check_eq("late rv req", {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk_i); #1;

    run_op(tbl[8]);
    check_eq("sb drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/segre_dmem_ctrl.md
Name: segre_dmem_ctrl

Overview:
Data-memory access controller between segre_mem_stage and the data memory bus. Takes the MEM stage's address, store data, size and read/write strobes and runs a multi-cycle request/grant/response transaction. Produces byte enables, aligned store data and right-aligned load data. Stalls the pipeline until the access completes; MEM stage applies sign/zero extension.

Parameters:
WORD_SIZE, 32, data/address width (from segre_pkg); byte-lane logic is fixed at 4 lanes.

Ports:
clk_i  in  1  clock, all state on rising edge
rsn_i  in  1  reset, synchronous, active-high (asserted = 1 resets)
memop_rd_i  in  1  load request from MEM stage
memop_wr_i  in  1  store request from MEM stage
addr_i  in  WORD_SIZE  byte address (MEM stage addr_o)
data_i  in  WORD_SIZE  store data, right-aligned (MEM stage data_o)
memop_type_i  in  memop_data_type_e  BYTE/HALF/WORD
data_o  out  WORD_SIZE  load data, right-aligned, unused upper bits zero
stall_o  out  1  hold pipeline; access in progress
misaligned_o  out  1  current request is misaligned; no bus access made
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  WORD_SIZE  word-aligned address (addr[1:0] forced 0)
mem_be_o  out  4  byte enables
mem_wdata_o  out  WORD_SIZE  lane-replicated store data
mem_gnt_i  in  1  bus accepted request this cycle
mem_rvalid_i  in  1  response valid (read data or write ack)
mem_rdata_i  in  WORD_SIZE  read data, full word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset: state=IDLE; all registered outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, data_o = 0).
- op = memop_rd_i | memop_wr_i. If both are set, it is a write (read ignored).
- Misaligned (combinational): HALF with addr_i[0]=1; WORD with addr_i[1:0]!=0. Then misaligned_o=1, stall_o=0, no transaction, FSM stays IDLE.
- stall_o = op & ~misaligned_o & (state != DONE). It is combinational, so it rises in the same cycle an op first appears.
- IDLE, op aligned: latch addr, type, we and offset = addr_i[1:0]. Compute be and wdata. Next state is REQ.
- Byte enables: BYTE = 4'b0001 << offset; HALF = 4'b0011 << offset; WORD = 4'b1111. Type encoding 3 is treated as WORD.
- Store data: BYTE gives data_i[7:0] replicated x4; HALF gives data_i[15:0] replicated x2; WORD gives data_i.
- REQ: mem_req_o=1 with stable addr/we/be/wdata until mem_gnt_i.
  - gnt without rvalid: go to WAIT.
  - gnt and rvalid in the same cycle: go straight to DONE.
- WAIT: mem_req_o=0. On mem_rvalid_i go to DONE. Writes also wait for rvalid as the ack.
- Response capture (reads): data_o <= mem_rdata_i >> (8*offset), masked to 8/16/32 bits by type. Writes leave data_o unchanged.
- DONE: stall_o=0 for exactly one cycle while data_o is valid; the pipeline advances at the end of this cycle. Next state is IDLE.
- Minimum latency: op seen in IDLE at cycle 0, REQ at 1, gnt+rvalid at 1, DONE at 2. Stall is high for cycles 0-1.
- mem_rvalid_i in IDLE or REQ-without-gnt is ignored.
- Reset mid-transaction: state returns to IDLE and mem_req_o drops next edge. Late rvalid is ignored.
- A new op in the cycle after DONE starts a fresh transaction; there is no back-to-back bypass.

Test Plan:
- Aligned LW addr 0x100, gnt at cycle 1, rvalid at cycle 3, rdata 0xDEADBEEF -> be=1111, mem_addr_o=0x100, stall_o high cycles 0-3, data_o=0xDEADBEEF in DONE (cycle 4).
- LB addr 0x103, gnt+rvalid same cycle, rdata 0x80112233 -> be=1000, DONE at cycle 2, data_o=0x00000080.
- SH addr 0x202, data_i 0x0000ABCD -> mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x200; completes on rvalid.
- LW addr 0x101 -> misaligned_o=1, stall_o=0, mem_req_o never asserts.
- gnt held low 5 cycles in REQ -> mem_req_o, addr, be and wdata stable all 5 cycles; stall_o held high.
- rsn_i=1 in WAIT, then rvalid arrives -> state IDLE, mem_req_o=0, data_o=0, stall_o=0 with no op present.
